wide_mag_comp_seq: RTL and testbench

//  Sequenced wide-operand magnitude comparator: reuses one C-bit combinational comparator

---
 rtl/wide_mag_comp_seq.sv | 137 +++++++++++++
 tb/tb_wide_mag_comp_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wide_mag_comp_seq.sv
// Sequenced W-bit unsigned magnitude comparator: one C-bit compare per cycle, MSB chunk first.
// Optional build macro WIDE_CMP_EARLY_EXIT_EN stops at the first unequal chunk.
module wide_mag_comp_seq #(
   parameter int W = 32,
   parameter int C = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic         e,
   output logic         g,
   output logic         l
);
   localparam int NCHUNK = W / C;
   localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int BW = (W > 1) ? $clog2(W) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);

   typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

   state_t        state, state_nx;
   logic [W-1:0]  a_r, b_r;
   logic [IW-1:0] idx;
   logic [BW-1:0] base;
   logic [C-1:0]  chunk_a, chunk_b;
   logic          chunk_gt, chunk_lt, last, finish, load;
`ifndef WIDE_CMP_EARLY_EXIT_EN
   logic          hit_r, gt_r;
`endif

   assign base     = BW'(idx * C);
   assign chunk_a  = a_r[base +: C];
   assign chunk_b  = b_r[base +: C];
   assign chunk_gt = (chunk_a > chunk_b);
   assign chunk_lt = (chunk_a < chunk_b);
   assign last     = (idx == '0);
`ifdef WIDE_CMP_EARLY_EXIT_EN
   assign finish   = last | chunk_gt | chunk_lt;
`else
   assign finish   = last;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      load     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = CMP;
            end
         end
         CMP: begin
            busy = 1'b1;
            if (finish) state_nx = DONE;
         end
         DONE: begin
            done = 1'b1;
            // back-to-back request is taken straight from the done cycle
            if (start) begin
               load     = 1'b1;
               state_nx = CMP;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_r   <= '0;
         b_r   <= '0;
         idx   <= '0;
         e     <= 1'b0;
         g     <= 1'b0;
         l     <= 1'b0;
`ifndef WIDE_CMP_EARLY_EXIT_EN
         hit_r <= 1'b0;
         gt_r  <= 1'b0;
`endif
      end else if (load) begin
         a_r   <= a;
         b_r   <= b;
         idx   <= IDX_TOP;
         e     <= 1'b0;
         g     <= 1'b0;
         l     <= 1'b0;
`ifndef WIDE_CMP_EARLY_EXIT_EN
         hit_r <= 1'b0;
         gt_r  <= 1'b0;
`endif
      end else if (state == CMP) begin
`ifdef WIDE_CMP_EARLY_EXIT_EN
         if (chunk_gt || chunk_lt) begin
            g <= chunk_gt;
            l <= chunk_lt;
         end else if (last) begin
            e <= 1'b1;
         end else begin
            idx <= idx - 1'b1;
         end
`else
         // first unequal chunk wins; lower chunks only matter if all above were equal
         if (!hit_r && (chunk_gt || chunk_lt)) begin
            hit_r <= 1'b1;
            gt_r  <= chunk_gt;
         end
         if (last) begin
            if (hit_r) begin
               g <= gt_r;
               l <= ~gt_r;
            end else begin
               g <= chunk_gt;
               l <= chunk_lt;
               e <= ~(chunk_gt | chunk_lt);
            end
         end else begin
            idx <= idx - 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_wide_mag_comp_seq.sv
// Self-checking bench for wide_mag_comp_seq (W=32, C=8): vector table, corner sequences, random ops.
module tb_wide_mag_comp_seq;
   localparam int W = 32;
   localparam int C = 8;
   localparam int NCHUNK = W / C;
`ifdef WIDE_CMP_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst, start;
   logic [W-1:0] a, b;
   logic         busy, done, e, g, l;

   int checks = 0;
   int errors = 0;

   wide_mag_comp_seq #(.W(W), .C(C)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .e(e), .g(g), .l(l)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         e;
      logic         g;
      logic         l;
      int           lat_early;
      string        name;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain unsigned compare; latency = chunks examined + 1 edges from the sampling edge.
   task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        output logic xe, output logic xg, output logic xl, output int lat);
      int k;
      logic [W-1:0] diff;
      xe = (ta == tb_v);
      xg = (ta > tb_v);
      xl = (ta < tb_v);
      k = NCHUNK;
      diff = ta ^ tb_v;
      if (EARLY) begin
         for (int i = NCHUNK - 1; i >= 0; i--) begin
            if (((diff >> (i * C)) & {{(W-C){1'b0}}, {C{1'b1}}}) != '0) begin
               k = NCHUNK - i;
               break;
            end
         end
      end
      lat = k + 1;
   endtask

   task automatic run_chk(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic xe, input logic xg, input logic xl,
                          input int xlat, input string name);
      int cnt;
      int bcnt;
      a = ta;
      b = tb_v;
      start = 1'b1;
      tick();
      start = 1'b0;
      cnt = 1;
      bcnt = 0;
      while (!done && cnt < 40) begin
         if (busy) bcnt++;
         tick();
         cnt++;
      end
      chk({name, "_latency"}, 32'(cnt), 32'(xlat));
      chk({name, "_busy_cycles"}, 32'(bcnt), 32'(xlat - 1));
      chk({name, "_egl"}, {29'b0, e, g, l}, {29'b0, xe, xg, xl});
      tick();
      chk({name, "_done_pulse"}, {31'b0, done}, 32'd0);
      chk({name, "_egl_held"}, {29'b0, e, g, l}, {29'b0, xe, xg, xl});
   endtask

   task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input string name);
      logic xe, xg, xl;
      int lat;
      model(ta, tb_v, xe, xg, xl, lat);
      run_chk(ta, tb_v, xe, xg, xl, lat, name);
   endtask

   initial begin
      int cnt;
      int dcnt;
      logic [2:0] res;
      logic [W-1:0] ra, rb;

      vecs[0] = '{32'h12345678, 32'h12345678, 1'b1, 1'b0, 1'b0, 5, "eq_pattern"};
      vecs[1] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 2, "msb_gt"};
      vecs[2] = '{32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b1, 5, "lsb_lt"};
      vecs[3] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 5, "zero_eq"};
      vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 5, "ones_gt"};
      vecs[5] = '{32'h00FF0000, 32'h00FE0000, 1'b0, 1'b1, 1'b0, 3, "chunk2_gt"};
      vecs[6] = '{32'h12000000, 32'h13000000, 1'b0, 1'b0, 1'b1, 2, "chunk3_lt"};
      vecs[7] = '{32'h01FF0000, 32'h02000000, 1'b0, 1'b0, 1'b1, 2, "lower_bigger"};

      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      tick();
      tick();
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_done", {31'b0, done}, 32'd0);
      chk("reset_egl", {29'b0, e, g, l}, 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) begin
         run_chk(vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].g, vecs[i].l,
                 EARLY ? vecs[i].lat_early : NCHUNK + 1, vecs[i].name);
      end

      // start while busy is ignored, one done pulse only
      a = 32'd5;
      b = 32'd9;
      start = 1'b1;
      tick();
      a = 32'd9;
      b = 32'd5;
      tick();
      tick();
      start = 1'b0;
      dcnt = 0;
      res = 3'b000;
      for (int i = 0; i < 10; i++) begin
         if (done) begin
            dcnt++;
            res = {e, g, l};
         end
         tick();
      end
      chk("ignore_start_dones", 32'(dcnt), 32'd1);
      chk("ignore_start_egl", {29'b0, res}, 32'b001);

      // reset mid-compare aborts without a done
      a = 32'hFF000000;
      b = 32'h00FFFFFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      rst = 1'b1;
      tick();
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_egl", {29'b0, e, g, l}, 32'd0);
      rst = 1'b0;
      dcnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (done || busy) dcnt++;
         tick();
      end
      chk("abort_no_activity", 32'(dcnt), 32'd0);
      run(32'd0, 32'd0, "after_abort");

      // back-to-back: start held through the done cycle
      a = 32'd1;
      b = 32'd2;
      start = 1'b1;
      tick();
      a = 32'd3;
      b = 32'd2;
      cnt = 1;
      while (!done && cnt < 40) begin
         tick();
         cnt++;
      end
      chk("b2b_first_latency", 32'(cnt), 32'(NCHUNK + 1));
      chk("b2b_first_egl", {29'b0, e, g, l}, 32'b001);
      tick();
      start = 1'b0;
      chk("b2b_no_gap_busy", {31'b0, busy}, 32'd1);
      chk("b2b_cleared_egl", {29'b0, e, g, l}, 32'd0);
      cnt = 1;
      while (!done && cnt < 40) begin
         tick();
         cnt++;
      end
      chk("b2b_second_latency", 32'(cnt), 32'(NCHUNK + 1));
      chk("b2b_second_egl", {29'b0, e, g, l}, 32'b010);
      tick();

      // random operands, biased so upper chunks often match
      for (int n = 0; n < 150; n++) begin
         ra = $urandom;
         rb = ra;
         for (int j = 0; j < NCHUNK; j++) begin
            if ($urandom_range(0, 2) == 0) rb = rb ^ (W'($urandom_range(1, 255)) << (j * C));
         end
         if ($urandom_range(0, 1) == 1) begin
            run(rb, ra, "random");
         end else begin
            run(ra, rb, "random");
         end
         for (int j = $urandom_range(0, 2); j > 0; j--) tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
